pkt_buf_reader: RTL and testbench
=================================

Name: pkt_buf_reader

Overview:
- Read side of the packet buffer BRAM (simple dual-port, native interface); the writer fills it through port A.
- Takes one packet descriptor at a time: start address, length in words, last-beat tkeep, and SUME metadata.
- Reads the words through port B and emits them as an AXI4-Stream master packet with tlast, tkeep and tuser.
- Sits between the PIFO dequeue logic and the output port; fully tolerates m_axis backpressure.

Parameters:
- DATA_WIDTH, 256, BRAM word and tdata width.
- SUME_META_WIDTH, 128, tuser width.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- ADDR_WIDTH, 11, BRAM address width; the buffer holds 2**ADDR_WIDTH words.
- LEN_WIDTH, 8, packet length field width, in words.
- BRAM_LATENCY, 1, port B read latency in cycles, from addrb/enb to valid doutb; legal values 1..2.
- FIFO_DEPTH, 4, output buffer entries; must be at least BRAM_LATENCY+2.

Ports:
- clk  in  1  single clock.
- resetn  in  1  asynchronous, active-low reset.
- desc_valid  in  1  descriptor valid.
- desc_ready  out  1  descriptor accepted when desc_valid && desc_ready.
- desc_addr  in  ADDR_WIDTH  BRAM address of the first word.
- desc_len  in  LEN_WIDTH  packet length in words; 0 is illegal.
- desc_keep  in  KEEP_WIDTH  tkeep for the last beat.
- desc_tuser  in  SUME_META_WIDTH  packet metadata.
- bram_enb  out  1  port B read enable.
- bram_addrb  out  ADDR_WIDTH  port B address.
- bram_doutb  in  DATA_WIDTH  port B read data.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  KEEP_WIDTH  output byte enables.
- m_axis_tuser  out  SUME_META_WIDTH  output metadata.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  last beat of packet.
- desc_err  out  1  one-cycle pulse when a zero-length descriptor is accepted.

Behaviour:
- Reset (async assert, sync deassert): desc_ready=0, bram_enb=0, bram_addrb=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep/tuser=0, desc_err=0, FIFO empty, state=IDLE.
- State IDLE: desc_ready=1.
  - On accept with len>0: latch addr, len, keep, tuser; go to READ.
  - On accept with len==0: pulse desc_err, stay in IDLE, emit nothing.
- State READ: desc_ready=0.
  - Each cycle, issue a read (bram_enb=1, addrb=rd_ptr) iff credit>0.
  - credit = FIFO_DEPTH - fifo_count - inflight.
  - rd_ptr increments modulo 2**ADDR_WIDTH, so 0x7FF wraps to 0x000.
  - Track issued count; after issuing word len-1, go to DRAIN.
- State DRAIN: wait for the handshake of the beat carrying tlast, then go to IDLE.
  - A new descriptor is accepted no earlier than the cycle after that handshake.
- Inflight tracking: a BRAM_LATENCY-deep valid shift register carries per-word tags (last flag) alongside each read. When a tag exits, bram_doutb is pushed into the FIFO.
- FIFO entry contents: {data, last}.
  - tkeep = last ? latched keep : all-ones.
  - tuser = latched desc_tuser on every beat of the packet.
- FIFO never overflows: credit accounting guarantees a free slot for every inflight word. Overflow is an assertion failure.
- Latency: descriptor accepted at edge T.
  - First bram_enb at cycle T+1.
  - First m_axis_tvalid at cycle T+1+BRAM_LATENCY+1, i.e. the FIFO is registered.
- Throughput: 1 beat/cycle when tready is held high and FIFO_DEPTH >= BRAM_LATENCY+2.
- AXI rules:
  - Once tvalid is asserted, tdata/tkeep/tuser/tlast stay stable until tready.
  - tvalid never depends combinationally on tready.
- Back-to-back packets: at least one idle tvalid cycle between packets is allowed; no interleaving.
- Reset mid-packet: everything is dropped immediately, outputs return to reset values, and no partial packet resumes.

Optional Feature:
- PKT_BUF_READER_STATS_EN defined: adds outputs stat_pkts [31:0] and stat_beats [31:0].
  - stat_pkts increments per tlast handshake; stat_beats increments per beat handshake.
  - Both are saturating counters, cleared by reset, plus a 1-bit input stat_clr that synchronously zeroes both.
- Not defined: no stat ports and no counter logic.

Decomposition:
- Package pkt_buf_pkg: state enum (IDLE, READ, DRAIN), the default widths above, and the FIFO entry struct {data, last}.
- One natural sub-module, pkt_buf_rd_fifo: a synchronous FIFO with count output, parameterised by width and depth, with registered outputs.

Test Plan:
- Descriptor addr=0x100, len=3, keep=0x0000FFFF, tuser=0x12341234, BRAM preloaded with 0xA0..0xA2, tready=1 → beats 0xA0, 0xA1, 0xA2 on consecutive cycles; tlast and keep=0x0000FFFF only on 0xA2; first tvalid 3 cycles after accept (BRAM_LATENCY=1).
- Wrap: addr=0x7FE, len=4 → bram_addrb sequence 0x7FE, 0x7FF, 0x000, 0x001; data order preserved.
- Backpressure: len=8, tready toggling 1/0 each cycle → all 8 beats delivered in order; no beat lost or duplicated; outputs stable while stalled; bram_enb stops whenever credit==0.
- len=0 descriptor → desc_err high for exactly 1 cycle, no tvalid, desc_ready stays high; the next descriptor, len=1, yields a single beat with tlast=1.
- Assert resetn=0 during beat 2 of a len=5 packet, release after 10 cycles → tvalid=0 immediately; after release, a new len=2 packet outputs exactly 2 beats.
- BRAM_LATENCY=2 run of the first scenario → identical data, first tvalid 4 cycles after accept; with PKT_BUF_READER_STATS_EN, stat_pkts=1 and stat_beats=3 afterwards.

Source files
------------

// File: rtl/pkt_buf_pkg.sv
// Shared types and default widths for the packet-buffer read side.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pkt_buf_pkg;

    localparam int DEF_DATA_WIDTH      = 256;
    localparam int DEF_SUME_META_WIDTH = 128;
    localparam int DEF_ADDR_WIDTH      = 11;
    localparam int DEF_LEN_WIDTH       = 8;
    localparam int DEF_BRAM_LATENCY    = 1;
    localparam int DEF_FIFO_DEPTH      = 4;

    // Reader sequencing: wait for descriptor, issue reads, wait for tlast to leave.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // Output FIFO entry at the default data width; the reader re-declares the
    // same layout at its parameterised width.
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic                      last;
    } fifo_entry_t;

endpackage

// File: rtl/pkt_buf_rd_fifo.sv
// Synchronous FIFO with a registered head (output) stage and an occupancy count.
// Latency: a write into an empty FIFO is visible on rd_vld/rd_dat the next cycle.
// Backpressure: head held stable while rd_vld && !rd_rdy; writer must never overfill.
module pkt_buf_rd_fifo #(
    parameter int WIDTH = 257,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic [CNT_W-1:0] count
);

    // The head register is one of the DEPTH slots; the ring holds the rest.
    localparam int RING = DEPTH - 1;
    localparam int PW   = (RING > 1) ? $clog2(RING) : 1;

    logic [WIDTH-1:0] ring_mem [RING];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CNT_W-1:0] ring_cnt;
    logic             load;
    logic             ring_rd;
    logic             ring_wr;
    logic             bypass;
    logic             ring_empty;
    logic             ring_full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ring_empty = (ring_cnt == '0);
    assign ring_full  = (ring_cnt == CNT_W'(RING));
    assign load       = !rd_vld || rd_rdy;
    assign ring_rd    = load && !ring_empty;
    assign bypass     = load && ring_empty && wr_vld;
    assign ring_wr    = wr_vld && !bypass;
    assign count      = ring_cnt + CNT_W'(rd_vld);

    // Head register refill (from ring, or straight from the write port) and pointers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_vld   <= 1'b0;
            rd_dat   <= '0;
            wp       <= '0;
            rp       <= '0;
            ring_cnt <= '0;
        end else begin
            if (ring_rd) begin
                rd_vld <= 1'b1;
                rd_dat <= ring_mem[rp];
                rp     <= ptr_inc(rp);
            end else if (bypass) begin
                rd_vld <= 1'b1;
                rd_dat <= wr_dat;
            end else if (load) begin
                rd_vld <= 1'b0;
            end
            if (ring_wr) begin
                wp <= ptr_inc(wp);
            end
            ring_cnt <= ring_cnt + CNT_W'(ring_wr) - CNT_W'(ring_rd);
        end
    end

    // Ring storage needs no reset: pointers decide what is live.
    always_ff @(posedge clk) begin
        if (ring_wr) begin
            ring_mem[wp] <= wr_dat;
        end
    end

    // The reader's credit scheme must always leave a slot for every word in flight.
    assert property (@(posedge clk) disable iff (!resetn) !(ring_wr && ring_full && !ring_rd));

endmodule

// File: rtl/pkt_buf_reader.sv
// Packet buffer read side: descriptor in, BRAM port-B reads, AXI4-Stream packet out.
// Latency: accept at edge T -> first bram_enb cycle T+1 -> first tvalid cycle T+BRAM_LATENCY+2.
// Backpressure: credit-based; reads stop when FIFO plus in-flight words reach FIFO_DEPTH.
// Optional: define PKT_BUF_READER_STATS_EN for saturating stat_pkts/stat_beats counters.
module pkt_buf_reader
    import pkt_buf_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int SUME_META_WIDTH = DEF_SUME_META_WIDTH,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH       = DEF_LEN_WIDTH,
    parameter int BRAM_LATENCY    = DEF_BRAM_LATENCY,  // 1..2
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH     // >= BRAM_LATENCY + 2 for full rate
) (
    input  logic                       clk,
    input  logic                       resetn,
`ifdef PKT_BUF_READER_STATS_EN
    input  logic                       stat_clr,
    output logic [31:0]                stat_pkts,
    output logic [31:0]                stat_beats,
`endif
    input  logic                       desc_valid,
    output logic                       desc_ready,
    input  logic [ADDR_WIDTH-1:0]      desc_addr,
    input  logic [LEN_WIDTH-1:0]       desc_len,
    input  logic [KEEP_WIDTH-1:0]      desc_keep,
    input  logic [SUME_META_WIDTH-1:0] desc_tuser,
    output logic                       bram_enb,
    output logic [ADDR_WIDTH-1:0]      bram_addrb,
    input  logic [DATA_WIDTH-1:0]      bram_doutb,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
    output logic [SUME_META_WIDTH-1:0] m_axis_tuser,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       desc_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } rd_entry_t;

    rd_state_t                state;
    rd_state_t                state_nxt;
    logic [ADDR_WIDTH-1:0]    rd_ptr;
    logic [LEN_WIDTH-1:0]     issued;
    logic [LEN_WIDTH-1:0]     len_q;
    logic [KEEP_WIDTH-1:0]    keep_q;
    logic [SUME_META_WIDTH-1:0] tuser_q;
    logic [BRAM_LATENCY-1:0]  tag_vld;
    logic [BRAM_LATENCY-1:0]  tag_last;
    logic [CNT_W-1:0]         fifo_cnt;
    logic [CNT_W-1:0]         inflight;
    logic [CNT_W:0]           occ;
    logic                     has_credit;
    logic                     accept;
    logic                     last_issue;
    logic                     beat_hs;
    rd_entry_t                push_ent;
    rd_entry_t                head_ent;

    assign accept     = desc_valid && desc_ready;
    assign last_issue = (issued == len_q - 1'b1);
    assign occ        = {1'b0, fifo_cnt} + {1'b0, inflight};
    assign has_credit = (occ < DEPTH_C);
    assign bram_addrb = rd_ptr;
    assign beat_hs    = m_axis_tvalid && m_axis_tready;

    // Count words whose read is issued but whose data has not reached the FIFO yet.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < BRAM_LATENCY; i++) begin
            inflight = inflight + CNT_W'(tag_vld[i]);
        end
    end

    // Next-state and read-enable decode.
    always_comb begin
        state_nxt = state;
        bram_enb  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && desc_len != '0) state_nxt = READ;
            end
            READ: begin
                bram_enb = has_credit;
                if (has_credit && last_issue) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (beat_hs && m_axis_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Descriptor capture, read pointer / issue count, handshake outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            desc_ready <= 1'b0;
            desc_err   <= 1'b0;
            rd_ptr     <= '0;
            issued     <= '0;
            len_q      <= '0;
            keep_q     <= '0;
            tuser_q    <= '0;
        end else begin
            desc_ready <= (state_nxt == IDLE);
            desc_err   <= accept && (desc_len == '0);
            if (accept && desc_len != '0) begin
                rd_ptr  <= desc_addr;
                issued  <= '0;
                len_q   <= desc_len;
                keep_q  <= desc_keep;
                tuser_q <= desc_tuser;
            end else if (bram_enb) begin
                rd_ptr <= rd_ptr + 1'b1;  // wraps naturally at 2**ADDR_WIDTH
                issued <= issued + 1'b1;
            end
        end
    end

    // Tag pipeline matching the BRAM read latency; exiting tag pushes doutb.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_vld  <= '0;
            tag_last <= '0;
        end else begin
            tag_vld[0]  <= bram_enb;
            tag_last[0] <= bram_enb && last_issue;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_last[i] <= tag_last[i-1];
            end
        end
    end

    assign push_ent = '{data: bram_doutb, last: tag_last[BRAM_LATENCY-1]};

    pkt_buf_rd_fifo #(
        .WIDTH ($bits(rd_entry_t)),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .wr_vld (tag_vld[BRAM_LATENCY-1]),
        .wr_dat (push_ent),
        .rd_vld (m_axis_tvalid),
        .rd_rdy (m_axis_tready),
        .rd_dat (head_ent),
        .count  (fifo_cnt)
    );

    // keep_q/tuser_q cannot change before the tlast beat leaves, so beats stay stable.
    assign m_axis_tdata = head_ent.data;
    assign m_axis_tlast = head_ent.last;
    assign m_axis_tkeep = !m_axis_tvalid ? '0 : (head_ent.last ? keep_q : '1);
    assign m_axis_tuser = tuser_q;

`ifdef PKT_BUF_READER_STATS_EN
    // Saturating packet/beat counters with synchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_pkts  <= '0;
            stat_beats <= '0;
        end else if (stat_clr) begin
            stat_pkts  <= '0;
            stat_beats <= '0;
        end else begin
            if (beat_hs && stat_beats != '1)                 stat_beats <= stat_beats + 1'b1;
            if (beat_hs && m_axis_tlast && stat_pkts != '1)  stat_pkts  <= stat_pkts + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pkt_buf_reader.sv
// Scoreboard bench for pkt_buf_reader: directed descriptors, BRAM model, output monitor.
// Latency: n/a.
// Backpressure: tready either held high or toggled every cycle.
`timescale 1ns/1ps
module tb_pkt_buf_reader;

    localparam int DW    = 256;
    localparam int MW    = 128;
    localparam int KW    = 32;
    localparam int AW    = 11;
    localparam int LW    = 8;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [MW-1:0] tuser;
        logic          last;
    } beat_t;

    logic          clk;
    logic          resetn;
    logic          desc_valid;
    logic          desc_ready;
    logic [AW-1:0] desc_addr;
    logic [LW-1:0] desc_len;
    logic [KW-1:0] desc_keep;
    logic [MW-1:0] desc_tuser;
    logic          bram_enb;
    logic [AW-1:0] bram_addrb;
    logic [DW-1:0] bram_doutb;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [MW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          desc_err;
`ifdef PKT_BUF_READER_STATS_EN
    logic          stat_clr;
    logic [31:0]   stat_pkts;
    logic [31:0]   stat_beats;
`endif

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [0:LAT-1];

    beat_t         exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            hs_cyc[$];
    int            n_chk = 0;
    int            n_pass = 0;
    int            hs_cnt = 0;
    int            cyc = 0;
    int            outst = 0;
    int            max_outst = 0;
    logic          bp_mode = 1'b0;

    pkt_buf_reader #(
        .DATA_WIDTH      (DW),
        .SUME_META_WIDTH (MW),
        .KEEP_WIDTH      (KW),
        .ADDR_WIDTH      (AW),
        .LEN_WIDTH       (LW),
        .BRAM_LATENCY    (LAT),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
`ifdef PKT_BUF_READER_STATS_EN
        .stat_clr      (stat_clr),
        .stat_pkts     (stat_pkts),
        .stat_beats    (stat_beats),
`endif
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .desc_addr     (desc_addr),
        .desc_len      (desc_len),
        .desc_keep     (desc_keep),
        .desc_tuser    (desc_tuser),
        .bram_enb      (bram_enb),
        .bram_addrb    (bram_addrb),
        .bram_doutb    (bram_doutb),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .desc_err      (desc_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM port B model with LAT cycles from enb/addr to doutb.
    always @(posedge clk) begin
        if (bram_enb) rd_pipe[0] <= mem[bram_addrb];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_doutb = rd_pipe[LAT-1];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // tready: held high, or toggled each cycle when bp_mode is set.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) m_axis_tready = ~m_axis_tready;
            else         m_axis_tready = 1'b1;
        end
    end

    // Monitor: beat scoreboard, stall stability, read address order, outstanding reads.
    initial begin
        logic  stall_q;
        beat_t held;
        beat_t e;
        stall_q = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                stall_q = 1'b0;
                outst   = 0;
            end else begin
                if (stall_q) begin
                    chk("hold_tvalid", DW'(m_axis_tvalid), DW'(1));
                    chk("hold_tdata", m_axis_tdata, held.data);
                    chk("hold_tkeep", DW'(m_axis_tkeep), DW'(held.keep));
                    chk("hold_tuser", DW'(m_axis_tuser), DW'(held.tuser));
                    chk("hold_tlast", DW'(m_axis_tlast), DW'(held.last));
                end
                if (bram_enb) begin
                    outst++;
                    if (addr_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_read: got addrb %h, required no read", bram_addrb);
                    end else begin
                        chk("bram_addrb", DW'(bram_addrb), DW'(addr_q.pop_front()));
                    end
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    hs_cnt++;
                    outst--;
                    hs_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_beat: got data %h, required no beat", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_tdata", m_axis_tdata, e.data);
                        chk("beat_tkeep", DW'(m_axis_tkeep), DW'(e.keep));
                        chk("beat_tuser", DW'(m_axis_tuser), DW'(e.tuser));
                        chk("beat_tlast", DW'(m_axis_tlast), DW'(e.last));
                    end
                end
                if (outst > max_outst) max_outst = outst;
                stall_q = m_axis_tvalid && !m_axis_tready;
                held    = '{data: m_axis_tdata, keep: m_axis_tkeep, tuser: m_axis_tuser, last: m_axis_tlast};
            end
        end
    end

    // Queue the expected beats/addresses, then present the descriptor until accepted.
    // Returns at the negedge of the cycle after the accepting edge.
    task automatic send_desc(input logic [AW-1:0] a, input logic [LW-1:0] len,
                             input logic [KW-1:0] k, input logic [MW-1:0] u);
        beat_t b;
        int    n;
        for (int i = 0; i < int'(len); i++) begin
            logic [AW-1:0] ai;
            ai      = a + AW'(i);
            b.data  = mem[ai];
            b.last  = (i == int'(len) - 1);
            b.keep  = b.last ? k : '1;
            b.tuser = u;
            exp_q.push_back(b);
            addr_q.push_back(ai);
        end
        @(negedge clk);
        desc_addr  = a;
        desc_len   = len;
        desc_keep  = k;
        desc_tuser = u;
        desc_valid = 1'b1;
        n = 0;
        while (!desc_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!desc_ready) begin
            n_chk++;
            $display("FAIL desc_accept_timeout: desc_ready 0 after %0d cycles, required 1", n);
        end
        @(posedge clk);
        @(negedge clk);
        desc_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !desc_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_beats_left"}, DW'(exp_q.size()), DW'(0));
        chk({name, "_reads_left"}, DW'(addr_q.size()), DW'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int k;
        int base;
        int n;
        resetn     = 1'b0;
        desc_valid = 1'b0;
        desc_addr  = '0;
        desc_len   = '0;
        desc_keep  = '0;
        desc_tuser = '0;
`ifdef PKT_BUF_READER_STATS_EN
        stat_clr   = 1'b0;
`endif
        for (int i = 0; i < (1 << AW); i++) mem[i] = {192'h0, 32'hD000_0000 + 32'(i), 32'(i)};
        mem[11'h100] = 256'hA0;
        mem[11'h101] = 256'hA1;
        mem[11'h102] = 256'hA2;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_desc_ready", DW'(desc_ready), DW'(0));
        chk("rst_bram_enb", DW'(bram_enb), DW'(0));
        chk("rst_bram_addrb", DW'(bram_addrb), DW'(0));
        chk("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
        chk("rst_tlast", DW'(m_axis_tlast), DW'(0));
        chk("rst_tdata", m_axis_tdata, DW'(0));
        chk("rst_tkeep", DW'(m_axis_tkeep), DW'(0));
        chk("rst_tuser", DW'(m_axis_tuser), DW'(0));
        chk("rst_desc_err", DW'(desc_err), DW'(0));
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_desc_ready", DW'(desc_ready), DW'(1));

        // Basic 3-word packet with latency and back-to-back beat checks.
        hs_cyc.delete();
        send_desc(11'h100, 8'd3, 32'h0000_FFFF, 128'h1234_1234);
        chk("s1_enb_first_cycle", DW'(bram_enb), DW'(1));
        k = 1;
        while (!m_axis_tvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("s1_first_tvalid_latency", DW'(k), DW'(LAT + 2));
        wait_idle("s1");
        chk("s1_beat_count", DW'(hs_cyc.size()), DW'(3));
        if (hs_cyc.size() == 3) chk("s1_consecutive", DW'(hs_cyc[2] - hs_cyc[0]), DW'(2));
`ifdef PKT_BUF_READER_STATS_EN
        chk("stat_pkts", DW'(stat_pkts), DW'(1));
        chk("stat_beats", DW'(stat_beats), DW'(3));
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        chk("stat_clr_pkts", DW'(stat_pkts), DW'(0));
        chk("stat_clr_beats", DW'(stat_beats), DW'(0));
`endif

        // Address wrap 0x7FE, 0x7FF, 0x000, 0x001.
        send_desc(11'h7FE, 8'd4, 32'h0000_000F, 128'hCAFE_0002);
        wait_idle("s2_wrap");

        // tready toggling every cycle.
        max_outst = 0;
        bp_mode = 1'b1;
        send_desc(11'h200, 8'd8, 32'h00FF_00FF, 128'hBEEF_0003);
        wait_idle("s3_bp");
        bp_mode = 1'b0;
        chk("s3_outstanding_le_depth", DW'(max_outst <= DEPTH), DW'(1));

        // Zero-length descriptor, then a single-beat packet.
        send_desc(11'h300, 8'd0, 32'hFFFF_FFFF, 128'h0);
        chk("s4_desc_err_pulse", DW'(desc_err), DW'(1));
        chk("s4_desc_ready_stays", DW'(desc_ready), DW'(1));
        @(negedge clk);
        chk("s4_desc_err_cleared", DW'(desc_err), DW'(0));
        repeat (3) @(negedge clk);
        chk("s4_no_tvalid", DW'(m_axis_tvalid), DW'(0));
        send_desc(11'h301, 8'd1, 32'h0000_0001, 128'h5555_0004);
        wait_idle("s4_len1");

        // Reset during beat 2 of a 5-beat packet.
        base = hs_cnt;
        send_desc(11'h400, 8'd5, 32'h0000_00FF, 128'h7777_0005);
        n = 0;
        while (hs_cnt < base + 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("s5_first_beat_seen", DW'(hs_cnt - base), DW'(1));
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("s5_rst_tvalid", DW'(m_axis_tvalid), DW'(0));
        chk("s5_rst_tdata", m_axis_tdata, DW'(0));
        chk("s5_rst_tlast", DW'(m_axis_tlast), DW'(0));
        chk("s5_rst_desc_ready", DW'(desc_ready), DW'(0));
        chk("s5_rst_bram_enb", DW'(bram_enb), DW'(0));
        exp_q.delete();
        addr_q.delete();
        repeat (10) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        base = hs_cnt;
        send_desc(11'h500, 8'd2, 32'h0000_0003, 128'h9999_0006);
        wait_idle("s5_after");
        repeat (4) @(negedge clk);
        chk("s5_after_beat_count", DW'(hs_cnt - base), DW'(2));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
